// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, redirect flush,
// stall hold and a terminal HALTED state left only through reset.
module fetch_stage #(
  parameter int         PC_WIDTH  = 8,
  parameter logic [8:0] NOP_INSTR = 9'b110110000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_in,
  input  logic [8:0]          imem_data,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [8:0]          if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic                if_id_valid,
  output logic                done,
  output logic [15:0]         fetch_count
);

  // state  | meaning
  // RUN    | fetching; redirects, halts and stalls are honoured
  // HALTED | everything frozen, IF/ID holds a bubble, done=1

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;

  // The ROM address is the PC register itself, so it only moves on edges.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      done        <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            // The word fetched this cycle is on the wrong path: squash it.
            pc          <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (halt_in) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            done        <= 1'b1;
            state       <= HALTED;
          end else if (!stall) begin
            if_id_instr <= imem_data;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + PC_WIDTH'(1);
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        HALTED: begin
          done <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/branch/halt/reset traffic against an abstract fetch model.
module tb_fetch_stage;

  localparam logic [8:0] NOP = 9'b110110000;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       halt_in;
  logic [8:0] imem_data;
  logic [7:0] imem_addr;
  logic [8:0] if_id_instr;
  logic [7:0] if_id_pc;
  logic       if_id_valid;
  logic       done;
  logic [15:0] fetch_count;

  logic [8:0] rom [256];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  m_pc;
  logic [8:0]  m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  logic        m_halted;
  int unsigned m_count;

  fetch_stage #(.PC_WIDTH(8), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_in(halt_in), .imem_data(imem_data),
    .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .done(done), .fetch_count(fetch_count)
  );

  assign imem_data = rom[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".instr"}, 32'(if_id_instr), 32'(m_instr));
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".if_pc"}, 32'(if_id_pc), 32'(m_ipc));
    chk({tag, ".done"}, 32'(done), 32'(m_halted));
    chk({tag, ".count"}, 32'(fetch_count), m_count);
  endtask

  // One clock edge: apply inputs, advance the model by the fetch rules, compare.
  task automatic step(input string tag, input logic rst, input logic stl,
                      input logic br, input logic [7:0] tgt, input logic hlt);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt; halt_in = hlt;
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 0; m_halted = 0; m_count = 0;
    end else if (!m_halted) begin
      if (br) begin
        m_pc = tgt; m_instr = NOP; m_valid = 0;
      end else if (hlt) begin
        m_instr = NOP; m_valid = 0; m_halted = 1;
      end else if (!stl) begin
        m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc = 8'((int'(m_pc) + 1) % 256);
        if (m_count < 65535) m_count++;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
    m_pc = 0; m_instr = NOP; m_ipc = 0; m_valid = 0; m_halted = 0; m_count = 0;

    step("reset", 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step("straight", 0, 0, 0, 8'h00, 0);
    chk("straight.count4", 32'(fetch_count), 32'd4);
    chk("straight.D", 32'(if_id_instr), 32'(rom[3]));

    step("reset2", 1, 0, 0, 8'h00, 0);
    step("pre_stall", 0, 0, 0, 8'h00, 0);
    step("pre_stall", 0, 0, 0, 8'h00, 0);
    step("stall", 0, 1, 0, 8'h00, 0);
    step("stall", 0, 1, 0, 8'h00, 0);
    chk("stall.holdB", 32'(if_id_instr), 32'(rom[1]));
    step("release", 0, 0, 0, 8'h00, 0);
    chk("release.C", 32'(if_id_instr), 32'(rom[2]));

    step("to_pc5", 0, 0, 0, 8'h00, 0);
    step("to_pc5", 0, 0, 0, 8'h00, 0);
    chk("at_pc5", 32'(imem_addr), 32'h05);
    step("branch", 0, 0, 1, 8'h20, 0);
    step("after_branch", 0, 0, 0, 8'h00, 0);
    chk("branch.target_word", 32'(if_id_instr), 32'(rom[8'h20]));

    step("br_stall_halt", 0, 1, 1, 8'h10, 1);
    chk("br_wins.pc", 32'(imem_addr), 32'h10);
    step("after_combo", 0, 0, 0, 8'h00, 0);

    step("wrap_br", 0, 0, 1, 8'hFE, 0);
    for (int i = 0; i < 3; i++) step("wrap", 0, 0, 0, 8'h00, 0);
    chk("wrap.pc", 32'(imem_addr), 32'h01);

    step("reset3", 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) step("to_pc7", 0, 0, 0, 8'h00, 0);
    step("halt", 0, 0, 0, 8'h00, 1);
    chk("halt.done", 32'(done), 32'd1);
    for (int i = 0; i < 10; i++)
      step("halted", 0, i[0], ~i[0], 8'($urandom), 1'($urandom));
    chk("halted.pc7", 32'(imem_addr), 32'h07);
    chk("halted.count7", 32'(fetch_count), 32'd7);
    step("reset_halted", 1, 1, 1, 8'h33, 1);
    chk("reset_halted.done", 32'(done), 32'd0);

    for (int i = 0; i < 600; i++) begin
      int unsigned r = $urandom_range(0, 99);
      step("random", r < 2, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           8'($urandom), $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
